// File: rtl/instr_fetch_pkg.sv
// Shared fetch configuration and instruction types for the front end.
// FETCH_WIDTH is the bundle slot count and must be a power of two.
package instr_fetch_pkg;

  // Configuration
  localparam int unsigned FETCH_WIDTH = 2;
  localparam int unsigned BLOCK_BYTES = 4 * FETCH_WIDTH;
  localparam logic [31:0] BLOCK_MASK  = 32'(BLOCK_BYTES - 1);

  // Instruction types
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } aligned_instr_t;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StPush
  } fetch_state_e;

  function automatic logic [31:0] block_base(input logic [31:0] pc);
    return pc & ~BLOCK_MASK;
  endfunction

  // Wraps modulo 2^32 past the top of the address space.
  function automatic logic [31:0] next_block(input logic [31:0] pc);
    return block_base(pc) + BLOCK_BYTES;
  endfunction

endpackage

// File: rtl/fetch_bundle_build.sv
// Turns one fetch-block response into bundle slots, masking off the
// words that sit before the fetch pc inside the block.
module fetch_bundle_build
  import instr_fetch_pkg::*;
(
  input  logic [31:0]                     i_pc,
  input  logic [32*FETCH_WIDTH-1:0]       i_data,
  output aligned_instr_t [FETCH_WIDTH-1:0] o_bundle
);

  logic [31:0] base;
  logic [31:0] word_off;

  always_comb begin
    base     = block_base(i_pc);
    word_off = (i_pc & BLOCK_MASK) >> 2;
    o_bundle = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (32'(k) >= word_off) begin
        o_bundle[k].valid = 1'b1;
        o_bundle[k].pc    = base + 32'(4 * k);
        o_bundle[k].instr = i_data[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding block request, then a held bundle
// pushed to the instruction queue. Flush redirects from any state.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic [31:0]                      i_redirect_pc,
  output logic                             o_mem_req,
  output logic [31:0]                      o_mem_addr,
  input  logic                             i_mem_ack,
  input  logic [32*FETCH_WIDTH-1:0]        i_mem_data,
  output logic                             o_enqueue,
  output aligned_instr_t [FETCH_WIDTH-1:0] o_instrs,
  input  logic                             i_can_enqueue
);

  fetch_state_e                     state_q;
  logic [31:0]                      pc_q;
  logic                             drop_q;
  logic                             armed_q;
  logic                             enq_q;
  aligned_instr_t [FETCH_WIDTH-1:0] bundle_q;
  aligned_instr_t [FETCH_WIDTH-1:0] bundle_d;
  logic                             mem_req;

  // armed_q keeps the request low until the first edge after reset.
  assign mem_req = (state_q == StReq) && armed_q && !drop_q;

  fetch_bundle_build u_build (
    .i_pc     (pc_q),
    .i_data   (i_mem_data),
    .o_bundle (bundle_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StReq;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      armed_q  <= 1'b0;
      enq_q    <= 1'b0;
      bundle_q <= '0;
    end else begin
      armed_q <= 1'b1;
      if (i_flush) begin
        state_q  <= StReq;
        pc_q     <= i_redirect_pc;
        enq_q    <= 1'b0;
        bundle_q <= '0;
        // A request still in flight (or issued this cycle) owes one ack to drop.
        drop_q   <= (drop_q && !i_mem_ack) || ((state_q == StWait) && !i_mem_ack) || mem_req;
      end else begin
        unique case (state_q)
          StReq: begin
            if (drop_q && i_mem_ack) drop_q <= 1'b0;
            if (mem_req) state_q <= StWait;
          end
          StWait: begin
            if (i_mem_ack) begin
              bundle_q <= bundle_d;
              enq_q    <= 1'b1;
              state_q  <= StPush;
            end
          end
          StPush: begin
            if (i_can_enqueue) begin
              pc_q     <= next_block(pc_q);
              bundle_q <= '0;
              enq_q    <= 1'b0;
              state_q  <= StReq;
            end
          end
          default: state_q <= StReq;
        endcase
      end
    end
  end

  assign o_mem_req  = mem_req;
  assign o_mem_addr = block_base(pc_q);
  assign o_enqueue  = enq_q;
  assign o_instrs   = bundle_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch with an in-bench fetch model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic                             i_clk = 1'b0;
  logic                             i_rst_n = 1'b0;
  logic                             i_flush = 1'b0;
  logic [31:0]                      i_redirect_pc = '0;
  logic                             i_mem_ack = 1'b0;
  logic [32*FETCH_WIDTH-1:0]        i_mem_data = '0;
  logic                             i_can_enqueue = 1'b1;
  logic                             o_mem_req;
  logic [31:0]                      o_mem_addr;
  logic                             o_enqueue;
  aligned_instr_t [FETCH_WIDTH-1:0] o_instrs;

  int total = 0;
  int bad   = 0;
  logic [31:0]                      model_pc;
  aligned_instr_t [FETCH_WIDTH-1:0] exp_b;

  instr_fetch #(.RESET_PC(RstPc)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_redirect_pc (i_redirect_pc),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_data    (i_mem_data),
    .o_enqueue     (o_enqueue),
    .o_instrs      (o_instrs),
    .i_can_enqueue (i_can_enqueue)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] blk(input logic [31:0] a);
    return a - (a % BLOCK_BYTES);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic chk_b(input string tag);
    total++;
    assert (o_instrs === exp_b)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o_instrs, exp_b);
    end
  endtask

  task automatic build_exp(input logic [31:0] pc, input logic [32*FETCH_WIDTH-1:0] data);
    logic [31:0] base;
    int unsigned off;
    base = blk(pc);
    off  = (pc - base) / 4;
    exp_b = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k >= off) begin
        exp_b[k].valid = 1'b1;
        exp_b[k].pc    = base + 32'(4 * k);
        exp_b[k].instr = data[32*k +: 32];
      end
    end
  endtask

  function automatic logic [32*FETCH_WIDTH-1:0] rand_data();
    logic [32*FETCH_WIDTH-1:0] d;
    for (int k = 0; k < FETCH_WIDTH; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // One block fetch starting in the request cycle; optionally flushes on the final push cycle.
  task automatic fetch_one(input int ack_dly, input int stalls, input bit flush_push,
                           input logic [31:0] redir);
    logic [32*FETCH_WIDTH-1:0] d;
    chk("req", o_mem_req, 1);
    chk("addr", o_mem_addr, blk(model_pc));
    chk("enq_idle", o_enqueue, 0);
    step();
    for (int i = 1; i < ack_dly; i++) begin
      chk("wait_req", o_mem_req, 0);
      chk("wait_enq", o_enqueue, 0);
      step();
    end
    d             = rand_data();
    i_mem_data    = d;
    i_mem_ack     = 1'b1;
    i_can_enqueue = (stalls == 0);
    step();
    i_mem_ack  = 1'b0;
    i_mem_data = rand_data();
    build_exp(model_pc, d);
    chk("enq", o_enqueue, 1);
    chk("push_req", o_mem_req, 0);
    chk_b("bundle");
    for (int i = 0; i < stalls; i++) begin
      i_mem_ack  = 1'($urandom_range(0, 1));
      i_mem_data = rand_data();
      step();
      chk("stall_enq", o_enqueue, 1);
      chk("stall_req", o_mem_req, 0);
      chk_b("stall_bundle");
    end
    i_mem_ack     = 1'b0;
    i_can_enqueue = 1'b1;
    if (flush_push) begin
      i_flush       = 1'b1;
      i_redirect_pc = redir;
    end
    step();
    i_flush  = 1'b0;
    model_pc = flush_push ? redir : blk(model_pc) + BLOCK_BYTES;
    exp_b    = '0;
    chk("enq_after", o_enqueue, 0);
    chk_b("instrs_clear");
  endtask

  initial begin
    // Reset state
    model_pc = RstPc;
    exp_b    = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req", o_mem_req, 0);
    chk("rst_enq", o_enqueue, 0);
    chk_b("rst_instrs");
    i_rst_n = 1'b1;
    step();

    // Straight-line fetch at full rate, then flush cancelling a push
    fetch_one(1, 0, 1'b0, '0);
    fetch_one(1, 0, 1'b0, '0);
    fetch_one(1, 0, 1'b1, 32'h0000_0204);
    fetch_one(1, 0, 1'b0, '0);
    chk("after_redirect_pc", model_pc, 32'h0000_0208);
    fetch_one(1, 4, 1'b0, '0);

    // Flush while waiting: stale ack three cycles later must be swallowed
    chk("w_req", o_mem_req, 1);
    step();
    i_flush       = 1'b1;
    i_redirect_pc = 32'h0000_0300;
    step();
    i_flush  = 1'b0;
    model_pc = 32'h0000_0300;
    for (int i = 0; i < 2; i++) begin
      chk("drop_req", o_mem_req, 0);
      chk("drop_enq", o_enqueue, 0);
      step();
    end
    i_mem_ack  = 1'b1;
    i_mem_data = rand_data();
    chk("drop_req_ack", o_mem_req, 0);
    step();
    i_mem_ack = 1'b0;
    chk("drop_addr", o_mem_addr, 32'h0000_0300);
    fetch_one(1, 0, 1'b0, '0);

    // Flush coincident with ack
    step();
    i_mem_ack     = 1'b1;
    i_mem_data    = rand_data();
    i_flush       = 1'b1;
    i_redirect_pc = 32'h0000_0404;
    step();
    i_mem_ack = 1'b0;
    i_flush   = 1'b0;
    model_pc  = 32'h0000_0404;
    chk("coinc_enq", o_enqueue, 0);
    fetch_one(1, 0, 1'b0, '0);

    // Address wrap at the top of memory
    fetch_one(2, 1, 1'b1, 32'hFFFF_FFF8);
    fetch_one(1, 0, 1'b0, '0);
    chk("wrap_pc", model_pc, 32'h0000_0000);
    fetch_one(1, 0, 1'b0, '0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      fetch_one(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset in the middle of a push
    step();
    i_mem_ack     = 1'b1;
    i_mem_data    = rand_data();
    i_can_enqueue = 1'b0;
    step();
    i_mem_ack = 1'b0;
    chk("pre_rst_enq", o_enqueue, 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    exp_b = '0;
    chk("async_rst_enq", o_enqueue, 0);
    chk("async_rst_req", o_mem_req, 0);
    chk_b("async_rst_instrs");
    @(posedge i_clk);
    #1;
    chk("held_rst_req", o_mem_req, 0);
    i_rst_n       = 1'b1;
    i_can_enqueue = 1'b1;
    step();
    model_pc = RstPc;
    fetch_one(1, 0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
